ram_16x8: RTL and testbench

//   Single-port synchronous RAM, 16 words x 8 bits by default, for small on-chip scratch storage.
//   Has one clock domain and one shared address for both read and write.

---
 rtl/ram_16x8.sv | 25 ++
 tb/tb_ram_16x8.sv | 93 +++++++++
 2 files changed

// File: rtl/ram_16x8.sv
// ram_16x8: single-port synchronous RAM with write-first registered read and synchronous clear
module ram_16x8 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] <= '0;
            dout <= '0;
        end else if (we) begin
            mem[addr] <= din;
            dout <= din;
        end else begin
            dout <= mem[addr];
        end
    end
endmodule

// File: tb/tb_ram_16x8.sv
// tb_ram_16x8: directed and random checks of ram_16x8 against an array model
module tb_ram_16x8;
    logic       clk = 0;
    logic       rst = 0;
    logic       we = 0;
    logic [3:0] addr = 0;
    logic [7:0] din = 0;
    logic [7:0] dout;
    int         passed = 0;
    int         total = 0;
    logic [7:0] model [16];
    logic [7:0] exp_dout;

    ram_16x8 dut (.clk(clk), .rst(rst), .we(we), .addr(addr), .din(din), .dout(dout));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step(input string tag, input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
        rst = r;
        we = w;
        addr = a;
        din = d;
        if (r) begin
            for (int i = 0; i < 16; i++) model[i] = 8'h00;
            exp_dout = 8'h00;
        end else if (w) begin
            model[a] = d;
            exp_dout = d;
        end else begin
            exp_dout = model[a];
        end
        @(posedge clk);
        #1;
        check(tag, dout, exp_dout);
    endtask

    initial begin
        step("reset", 1, 0, 0, 8'h00);
        check("reset_const", dout, 8'h00);
        for (int i = 0; i < 16; i++) begin
            step("read_after_reset", 0, 0, 4'(i), 8'h00);
            check("read_after_reset_const", dout, 8'h00);
        end
        step("wr1", 0, 1, 1, 8'hA5);
        check("wr1_const", dout, 8'hA5);
        step("wr2", 0, 1, 2, 8'h3C);
        check("wr2_const", dout, 8'h3C);
        step("wr3", 0, 1, 3, 8'hFF);
        check("wr3_const", dout, 8'hFF);
        step("rd1", 0, 0, 1, 8'h00);
        check("rd1_const", dout, 8'hA5);
        step("rd2", 0, 0, 2, 8'h00);
        check("rd2_const", dout, 8'h3C);
        step("rd3", 0, 0, 3, 8'h00);
        check("rd3_const", dout, 8'hFF);
        addr = 4'd1;
        #2;
        check("dout_registered", dout, 8'hFF);
        step("overwrite", 0, 1, 1, 8'h5A);
        step("rd_overwrite", 0, 0, 1, 8'h00);
        check("rd_overwrite_const", dout, 8'h5A);
        step("rd_neighbour", 0, 0, 2, 8'h00);
        check("rd_neighbour_const", dout, 8'h3C);
        step("rst_prio", 1, 1, 4, 8'h77);
        check("rst_prio_const", dout, 8'h00);
        step("rd4_after_rst", 0, 0, 4, 8'h00);
        check("rd4_after_rst_const", dout, 8'h00);
        step("rd1_after_rst", 0, 0, 1, 8'h00);
        check("rd1_after_rst_const", dout, 8'h00);
        step("wr_addr0", 0, 1, 0, 8'h11);
        step("wr_addr15", 0, 1, 15, 8'hEE);
        step("rd_addr0", 0, 0, 0, 8'h00);
        check("rd_addr0_const", dout, 8'h11);
        step("rd_addr15", 0, 0, 15, 8'h00);
        check("rd_addr15_const", dout, 8'hEE);
        for (int n = 0; n < 400; n++) begin
            logic r;
            logic w;
            r = ($urandom_range(0, 39) == 0);
            w = $urandom_range(0, 1) == 1;
            step(r ? "rand_rst" : (w ? "rand_wr" : "rand_rd"), r, w, 4'($urandom_range(0, 15)), 8'($urandom));
        end
        for (int i = 0; i < 16; i++) step("final_read", 0, 0, 4'(i), 8'h00);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
